// File: rtl/complex_mult_arbiter.sv
// Round-robin arbiter that feeds two requesters into one shared pipelined 18x17
// complex multiplier and routes each product back to the requester that issued it.
module complex_mult_arbiter #(
   parameter int unsigned LATENCY = 4
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req0_valid,
   output logic               o_req0_ready,
   input  logic signed [17:0] i_req0_ar,
   input  logic signed [17:0] i_req0_ai,
   input  logic signed [16:0] i_req0_br,
   input  logic signed [16:0] i_req0_bi,
   input  logic               i_req1_valid,
   output logic               o_req1_ready,
   input  logic signed [17:0] i_req1_ar,
   input  logic signed [17:0] i_req1_ai,
   input  logic signed [16:0] i_req1_br,
   input  logic signed [16:0] i_req1_bi,
   output logic signed [17:0] o_ar,
   output logic signed [17:0] o_ai,
   output logic signed [16:0] o_br,
   output logic signed [16:0] o_bi,
   input  logic signed [34:0] i_pr,
   input  logic signed [34:0] i_pi,
   output logic               o_res0_valid,
   output logic signed [34:0] o_res0_pr,
   output logic signed [34:0] o_res0_pi,
   output logic               o_res1_valid,
   output logic signed [34:0] o_res1_pr,
   output logic signed [34:0] o_res1_pi,
   output logic [15:0]        o_issue_cnt0,
   output logic [15:0]        o_issue_cnt1
);

   logic               last_grant;   // 1 when requester 1 won the most recent transfer
   logic               xfer0;
   logic               xfer1;
   logic [LATENCY:0]   sr_valid;
   logic [LATENCY:0]   sr_tag;

   // Requester 0 wins contention whenever requester 1 was served last.
   always_comb begin
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      if (!i_rst) begin
         if (i_req0_valid && (!i_req1_valid || last_grant)) begin
            o_req0_ready = 1'b1;
         end else if (i_req1_valid) begin
            o_req1_ready = 1'b1;
         end
      end
   end

   always_comb begin
      xfer0 = i_req0_valid && o_req0_ready;
      xfer1 = i_req1_valid && o_req1_ready;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_grant <= 1'b1;
      end else if (xfer0 || xfer1) begin
         last_grant <= xfer1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ar <= '0;
         o_ai <= '0;
         o_br <= '0;
         o_bi <= '0;
      end else if (xfer0) begin
         o_ar <= i_req0_ar;
         o_ai <= i_req0_ai;
         o_br <= i_req0_br;
         o_bi <= i_req0_bi;
      end else if (xfer1) begin
         o_ar <= i_req1_ar;
         o_ai <= i_req1_ai;
         o_br <= i_req1_br;
         o_bi <= i_req1_bi;
      end else begin
         o_ar <= '0;
         o_ai <= '0;
         o_br <= '0;
         o_bi <= '0;
      end
   end

   // Stage LATENCY lines up with the multiplier output for the operands issued LATENCY+1 edges ago.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sr_valid <= '0;
         sr_tag   <= '0;
      end else begin
         sr_valid <= {sr_valid[LATENCY-1:0], xfer0 || xfer1};
         sr_tag   <= {sr_tag[LATENCY-1:0], xfer1};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_issue_cnt0 <= '0;
         o_issue_cnt1 <= '0;
      end else begin
         if (xfer0) begin
            o_issue_cnt0 <= o_issue_cnt0 + 16'd1;
         end
         if (xfer1) begin
            o_issue_cnt1 <= o_issue_cnt1 + 16'd1;
         end
      end
   end

   always_comb begin
      o_res0_valid = !i_rst && sr_valid[LATENCY] && !sr_tag[LATENCY];
      o_res1_valid = !i_rst && sr_valid[LATENCY] &&  sr_tag[LATENCY];
      o_res0_pr    = o_res0_valid ? i_pr : '0;
      o_res0_pi    = o_res0_valid ? i_pi : '0;
      o_res1_pr    = o_res1_valid ? i_pr : '0;
      o_res1_pi    = o_res1_valid ? i_pi : '0;
   end

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Directed bench for complex_mult_arbiter with a behavioural pipelined multiplier
// closing the loop from o_ar/o_ai/o_br/o_bi back to i_pr/i_pi.
module tb_complex_mult_arbiter;

   localparam int unsigned LAT = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               v0, v1;
   logic               rdy0, rdy1;
   logic signed [17:0] a0r, a0i, a1r, a1i;
   logic signed [16:0] b0r, b0i, b1r, b1i;
   logic signed [17:0] o_ar, o_ai;
   logic signed [16:0] o_br, o_bi;
   logic signed [34:0] i_pr, i_pi;
   logic               res0_v, res1_v;
   logic signed [34:0] res0_pr, res0_pi, res1_pr, res1_pi;
   logic [15:0]        cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   complex_mult_arbiter #(.LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(v0), .o_req0_ready(rdy0),
      .i_req0_ar(a0r), .i_req0_ai(a0i), .i_req0_br(b0r), .i_req0_bi(b0i),
      .i_req1_valid(v1), .o_req1_ready(rdy1),
      .i_req1_ar(a1r), .i_req1_ai(a1i), .i_req1_br(b1r), .i_req1_bi(b1i),
      .o_ar(o_ar), .o_ai(o_ai), .o_br(o_br), .o_bi(o_bi),
      .i_pr(i_pr), .i_pi(i_pi),
      .o_res0_valid(res0_v), .o_res0_pr(res0_pr), .o_res0_pi(res0_pi),
      .o_res1_valid(res1_v), .o_res1_pr(res1_pr), .o_res1_pi(res1_pi),
      .o_issue_cnt0(cnt0), .o_issue_cnt1(cnt1)
   );

   // Shared multiplier: LAT register stages from operand outputs to product inputs.
   logic signed [34:0] pr_pipe [LAT];
   logic signed [34:0] pi_pipe [LAT];
   longint mul_r, mul_i;
   always @(posedge clk) begin
      mul_r = longint'(o_ar) * longint'(o_br) - longint'(o_ai) * longint'(o_bi);
      mul_i = longint'(o_ar) * longint'(o_bi) + longint'(o_ai) * longint'(o_br);
      pr_pipe[0] <= mul_r[34:0];
      pi_pipe[0] <= mul_i[34:0];
      for (int k = 1; k < LAT; k++) begin
         pr_pipe[k] <= pr_pipe[k-1];
         pi_pipe[k] <= pi_pipe[k-1];
      end
   end
   assign i_pr = pr_pipe[LAT-1];
   assign i_pi = pi_pipe[LAT-1];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      v0  = 1'b0;
      v1  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic               v0, v1;
      logic signed [17:0] a0r, a0i, a1r, a1i;
      logic signed [16:0] b0r, b0i, b1r, b1i;
      int                 id;       // granted requester, -1 for none
      longint             pr, pi;
   } vec_t;

   function automatic vec_t mk(input logic pv0, input logic pv1,
                               input longint p0ar, input longint p0ai, input longint p0br, input longint p0bi,
                               input longint p1ar, input longint p1ai, input longint p1br, input longint p1bi,
                               input int pid, input longint ppr, input longint ppi);
      vec_t r;
      r.v0  = pv0;        r.v1  = pv1;
      r.a0r = 18'(p0ar);  r.a0i = 18'(p0ai);
      r.b0r = 17'(p0br);  r.b0i = 17'(p0bi);
      r.a1r = 18'(p1ar);  r.a1i = 18'(p1ai);
      r.b1r = 17'(p1br);  r.b1i = 17'(p1bi);
      r.id  = pid;        r.pr  = ppr;       r.pi = ppi;
      return r;
   endfunction

   vec_t vecs [9];
   int   exp_cnt0, exp_cnt1;
   longint g_ar, g_ai, g_br, g_bi;

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Round-robin history starts with requester 0 favoured after reset.
      vecs[0] = mk(1, 0,      1,      7,     4,    -3,      0,      0,     0,     0, 0,          25,          25);
      vecs[1] = mk(0, 1,      0,      0,     0,     0,     -1,     -2,    -3,    -4, 1,          -5,          10);
      vecs[2] = mk(1, 0, -131072,     0, -65536,    0,      0,      0,     0,     0, 0, 64'd8589934592,       0);
      vecs[3] = mk(1, 1,      5,      0,     5,     0,      3,      4,     2,    -1, 1,          10,           5);
      vecs[4] = mk(1, 1,      5,      0,     5,     0,      3,      4,     2,    -1, 0,          25,           0);
      vecs[5] = mk(0, 0,      9,      9,     9,     9,      9,      9,     9,     9, -1,          0,           0);
      vecs[6] = mk(0, 1,      0,      0,     0,     0, 131071, 131071, 65535, 65535, 1,           0, 64'd17179475970);
      vecs[7] = mk(1, 0,    100,    -50,    -7,     3,      0,      0,     0,     0, 0,        -550,         650);
      vecs[8] = mk(1, 1,      2,      2,     3,     0,      1,      1,     1,     1, 1,           0,           2);

      {a0r, a0i, a1r, a1i} = '0;
      {b0r, b0i, b1r, b1i} = '0;

      // Reset state, with both valids asserted during reset.
      rst = 1'b1; v0 = 1'b1; v1 = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_rdy0", longint'(rdy0), 0);
      chk("rst_rdy1", longint'(rdy1), 0);
      chk("rst_res0_v", longint'(res0_v), 0);
      chk("rst_res1_v", longint'(res1_v), 0);
      chk("rst_o_ar", longint'(o_ar), 0);
      chk("rst_cnt0", longint'(cnt0), 0);
      chk("rst_cnt1", longint'(cnt1), 0);
      @(posedge clk);
      #1 rst = 1'b0; v0 = 1'b0; v1 = 1'b0;

      exp_cnt0 = 0;
      exp_cnt1 = 0;
      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         v0 = vecs[i].v0;   v1 = vecs[i].v1;
         a0r = vecs[i].a0r; a0i = vecs[i].a0i; b0r = vecs[i].b0r; b0i = vecs[i].b0i;
         a1r = vecs[i].a1r; a1i = vecs[i].a1i; b1r = vecs[i].b1r; b1i = vecs[i].b1i;
         g_ar = 0; g_ai = 0; g_br = 0; g_bi = 0;
         if (vecs[i].id == 0) begin
            g_ar = vecs[i].a0r; g_ai = vecs[i].a0i; g_br = vecs[i].b0r; g_bi = vecs[i].b0i;
            exp_cnt0++;
         end else if (vecs[i].id == 1) begin
            g_ar = vecs[i].a1r; g_ai = vecs[i].a1i; g_br = vecs[i].b1r; g_bi = vecs[i].b1i;
            exp_cnt1++;
         end
         @(negedge clk);
         chk($sformatf("v%0d_rdy0", i), longint'(rdy0), longint'(vecs[i].id == 0));
         chk($sformatf("v%0d_rdy1", i), longint'(rdy1), longint'(vecs[i].id == 1));
         @(posedge clk);
         #1 v0 = 1'b0; v1 = 1'b0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
               chk($sformatf("v%0d_o_ar", i), longint'(o_ar), g_ar);
               chk($sformatf("v%0d_o_ai", i), longint'(o_ai), g_ai);
               chk($sformatf("v%0d_o_br", i), longint'(o_br), g_br);
               chk($sformatf("v%0d_o_bi", i), longint'(o_bi), g_bi);
            end
            if (k == 1) begin
               chk($sformatf("v%0d_o_ar_idle", i), longint'(o_ar), 0);
               chk($sformatf("v%0d_o_bi_idle", i), longint'(o_bi), 0);
            end
            if (k < 4) begin
               chk($sformatf("v%0d_early_res0_v", i), longint'(res0_v), 0);
               chk($sformatf("v%0d_early_res1_v", i), longint'(res1_v), 0);
            end else begin
               chk($sformatf("v%0d_res0_v", i), longint'(res0_v), longint'(vecs[i].id == 0));
               chk($sformatf("v%0d_res1_v", i), longint'(res1_v), longint'(vecs[i].id == 1));
               chk($sformatf("v%0d_res0_pr", i), longint'(res0_pr), (vecs[i].id == 0) ? vecs[i].pr : 0);
               chk($sformatf("v%0d_res0_pi", i), longint'(res0_pi), (vecs[i].id == 0) ? vecs[i].pi : 0);
               chk($sformatf("v%0d_res1_pr", i), longint'(res1_pr), (vecs[i].id == 1) ? vecs[i].pr : 0);
               chk($sformatf("v%0d_res1_pi", i), longint'(res1_pi), (vecs[i].id == 1) ? vecs[i].pi : 0);
            end
         end
      end
      chk("tbl_cnt0", longint'(cnt0), longint'(exp_cnt0));
      chk("tbl_cnt1", longint'(cnt1), longint'(exp_cnt1));

      // Sustained contention: alternating grants and back-to-back results.
      do_reset();
      v0 = 1'b1; v1 = 1'b1;
      a0r = 1;  a0i = 7;  b0r = 4;  b0i = -3;
      a1r = -1; a1i = -2; b1r = -3; b1i = -4;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c < 6) begin
            chk($sformatf("rr%0d_rdy0", c), longint'(rdy0), longint'(c % 2 == 0));
            chk($sformatf("rr%0d_rdy1", c), longint'(rdy1), longint'(c % 2 == 1));
         end
         if (c >= 5 && c <= 10) begin
            if ((c - 5) % 2 == 0) begin
               chk($sformatf("rr%0d_res0_v", c), longint'(res0_v), 1);
               chk($sformatf("rr%0d_res1_v", c), longint'(res1_v), 0);
               chk($sformatf("rr%0d_res0_pr", c), longint'(res0_pr), 25);
               chk($sformatf("rr%0d_res0_pi", c), longint'(res0_pi), 25);
               chk($sformatf("rr%0d_res1_pr", c), longint'(res1_pr), 0);
            end else begin
               chk($sformatf("rr%0d_res0_v", c), longint'(res0_v), 0);
               chk($sformatf("rr%0d_res1_v", c), longint'(res1_v), 1);
               chk($sformatf("rr%0d_res1_pr", c), longint'(res1_pr), -5);
               chk($sformatf("rr%0d_res1_pi", c), longint'(res1_pi), 10);
               chk($sformatf("rr%0d_res0_pr", c), longint'(res0_pr), 0);
            end
         end else begin
            chk($sformatf("rr%0d_res0_v", c), longint'(res0_v), 0);
            chk($sformatf("rr%0d_res1_v", c), longint'(res1_v), 0);
         end
         @(posedge clk);
         #1;
         if (c == 5) begin
            v0 = 1'b0; v1 = 1'b0;
         end
      end
      chk("rr_cnt0", longint'(cnt0), 3);
      chk("rr_cnt1", longint'(cnt1), 3);

      // Reset while two products are in flight.
      do_reset();
      v0 = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rdy0", longint'(rdy0), 0);
      chk("mid_rst_res0_v", longint'(res0_v), 0);
      @(posedge clk);
      #1 rst = 1'b0; v0 = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) chk("mid_o_ar", longint'(o_ar), 0);
         chk($sformatf("mid%0d_res0_v", c), longint'(res0_v), 0);
         chk($sformatf("mid%0d_res1_v", c), longint'(res1_v), 0);
      end
      chk("mid_cnt0", longint'(cnt0), 0);
      chk("mid_cnt1", longint'(cnt1), 0);

      // Issue counter wrap after 65536 transfers.
      do_reset();
      v0 = 1'b1;
      repeat (65535) @(posedge clk);
      #1 chk("wrap_cnt0_ffff", longint'(cnt0), 65535);
      @(posedge clk);
      #1 chk("wrap_cnt0_zero", longint'(cnt0), 0);
      @(posedge clk);
      #1 v0 = 1'b0;
      chk("wrap_cnt0_one", longint'(cnt0), 1);
      chk("wrap_cnt1", longint'(cnt1), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/complex_mult_arbiter.md
COMPLEX_MULT_ARBITER -- requirements
Module: complex_mult_arbiter

Interface
Parameter:
REQ-001 The block SHALL have parameter LATENCY, default 4, the clock-cycle latency from the multiplier operand inputs to its product outputs.

Ports (name  direction  width  meaning):
REQ-002 The block SHALL have i_clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have i_rst  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL have i_reqN_valid  in  1  requester N (N=0,1) offers an operand set.
REQ-005 The block SHALL have o_reqN_ready  out  1  requester N operand set accepted this cycle.
REQ-006 The block SHALL have i_reqN_ar, i_reqN_ai  in  18  requester N operand A, real/imag, two's complement.
REQ-007 The block SHALL have i_reqN_br, i_reqN_bi  in  17  requester N operand B, real/imag, two's complement.
REQ-008 The block SHALL have o_ar, o_ai / o_br, o_bi  out  18 / 17  operands to the shared 18x17 complex multiplier.
REQ-009 The block SHALL have i_pr, i_pi  in  35  product from the multiplier, real/imag.
REQ-010 The block SHALL have o_resN_valid  out  1  result for requester N present this cycle.
REQ-011 The block SHALL have o_resN_pr, o_resN_pi  out  35  result for requester N, real/imag.
REQ-012 The block SHALL have o_issue_cnt0, o_issue_cnt1  out  16  accepted-transfer count per requester.

Function
REQ-013 Transfer on requester N SHALL occur when i_reqN_valid and o_reqN_ready are both 1 on a rising edge.
REQ-014 o_reqN_ready SHALL be combinational from the valids and the last-grant register; at most one ready is 1 per cycle.
REQ-015 Only one valid high: that requester SHALL be granted. Neither valid high: both readies SHALL be 0.
REQ-016 Both valids high: the requester not granted most recently SHALL be granted (round-robin).
REQ-017 The last-grant register SHALL update only on a transfer, to the granted index.
REQ-018 On transfer, o_ar/o_ai/o_br/o_bi SHALL register the granted operands unmodified at the next edge.
REQ-019 With no transfer, o_ar/o_ai/o_br/o_bi SHALL be driven to 0 at the next edge.
REQ-020 A valid+tag shift register of depth LATENCY+1 SHALL track each transfer; no input backpressure.
REQ-021 A result SHALL appear LATENCY+1 cycles after its transfer edge: o_resN_valid=1 for one cycle, N = tag.
REQ-022 o_resN_pr/pi SHALL equal i_pr/i_pi combinationally while o_resN_valid=1, and 0 otherwise.
REQ-023 Back-to-back transfers SHALL sustain one result per cycle, each routed by its own tag; results SHALL never be lost or reordered.
REQ-024 o_issue_cntN SHALL increment by 1 per transfer of requester N and wrap 16'hFFFF -> 0.
REQ-025 A requester holding valid SHALL keep its operands stable until its transfer; the block SHALL NOT check this.

Reset
REQ-026 With i_rst=1 at an edge, the next state SHALL be: o_ar/ai/br/bi=0, shift register cleared, o_issue_cnt0/1=0, last-grant=1 (requester 0 wins the first contention).
REQ-027 While i_rst=1, o_req0_ready, o_req1_ready, o_res0_valid and o_res1_valid SHALL be 0.
REQ-028 Reset mid-operation SHALL discard in-flight products: no o_resN_valid for any transfer made before reset, even if i_pr/i_pi later carry its product.

Verification (LATENCY=4, bench instances the real multiplier)
REQ-029 req0 only, A=1+7j, B=4-3j, transfer at edge T -> o_res0_valid at edge T+5, o_res0_pr=25, o_res0_pi=25, o_res1_valid=0.
REQ-030 req1 only, A=-1-2j, B=-3-4j -> o_res1_valid after 5 cycles, o_res1_pr=-5, o_res1_pi=10.
REQ-031 Both valids held high for 6 cycles after reset -> grants 0,1,0,1,0,1; results alternate res0/res1 on 6 consecutive cycles, each with the correct product.
REQ-032 Transfers at T and T+1, i_rst pulsed at T+2 -> no o_resN_valid in cycles T+2..T+7; counters read 0.
REQ-033 65537 req0 transfers -> o_issue_cnt0=1, o_issue_cnt1=0.
REQ-034 A=(-131072)+0j, B=(-65536)+0j -> o_res0_pr=8589934592 (35-bit full range), o_res0_pi=0.
